alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 211 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add/sub ops, bit-serial shifts and a
// shift-add multiplier behind a valid/ready request and result handshake.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inOne,
    input  logic [WIDTH-1:0] inTwo,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_PASS = 4'b1101;
    localparam logic [3:0] OP_ZERO = 4'b0111;
    localparam logic [3:0] OP_LSL  = 4'b0011;
    localparam logic [3:0] OP_LSR  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic             c;
        logic             v;
        logic [WIDTH-1:0] r;
    } alu_res_t;

    // Ops that finish on the accept edge; shifts land here only with amount 0.
    function automatic alu_res_t single_op(input logic [3:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        alu_res_t               res;
        logic [WIDTH:0]         wide;
        logic signed [WIDTH-1:0] sa, sb, sr;
        res  = '0;
        wide = '0;
        sa   = $signed(a);
        sb   = $signed(b);
        sr   = '0;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                res.r = wide[WIDTH-1:0];
                res.c = wide[WIDTH];
                sr    = sa + sb;
                res.v = (sa[WIDTH-1] == sb[WIDTH-1]) && (sr[WIDTH-1] != sa[WIDTH-1]);
            end
            OP_SUB: begin
                res.r = a - b;
                res.c = (a >= b);
                sr    = sa - sb;
                res.v = (sa[WIDTH-1] != sb[WIDTH-1]) && (sr[WIDTH-1] != sa[WIDTH-1]);
            end
            OP_AND:  res.r = a & b;
            OP_OR:   res.r = a | b;
            OP_XOR:  res.r = a ^ b;
            OP_NOR:  res.r = ~(a | b);
            OP_NAND: res.r = ~(a & b);
            OP_PASS: res.r = a;
            OP_ZERO: res.r = '0;
            OP_LSL:  res.r = a;
            OP_LSR:  res.r = a;
            default: res.r = '0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic c,
                                              input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    alu_res_t         sres;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] step_acc;
    logic             step_c;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        sres        = single_op(opcode, inOne, inTwo);
        shamt       = inTwo[SHW-1:0];
        step_acc    = acc_q;
        step_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d       = opcode;
                    in_ready_d = 1'b0;
                    if (opcode == OP_MUL) begin
                        acc_d   = '0;
                        a_d     = inOne;
                        b_d     = inTwo;
                        cnt_d   = CW'(WIDTH);
                        state_d = BUSY;
                    end else if ((opcode == OP_LSL || opcode == OP_LSR) && shamt != '0) begin
                        acc_d   = inOne;
                        cnt_d   = CW'(shamt);
                        state_d = BUSY;
                    end else begin
                        result_d    = sres.r;
                        flags_d     = make_flags(sres.r, sres.c, sres.v);
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    step_acc = b_q[0] ? (acc_q + a_q) : acc_q;
                    a_d      = {a_q[WIDTH-2:0], 1'b0};
                    b_d      = {1'b0, b_q[WIDTH-1:1]};
                end else if (op_q == OP_LSL) begin
                    step_acc = {acc_q[WIDTH-2:0], 1'b0};
                    step_c   = acc_q[WIDTH-1];
                end else begin
                    step_acc = {1'b0, acc_q[WIDTH-1:1]};
                    step_c   = acc_q[0];
                end
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
                // The final step's shifted-out bit becomes the shift carry.
                if (cnt_q == CW'(1)) begin
                    result_d    = step_acc;
                    flags_d     = make_flags(step_acc, (op_q == OP_MUL) ? 1'b0 : step_c, 1'b0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
        end
    end

    // Working datapath needs no reset: it is always reloaded on accept.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32): latency, result and {N,Z,C,V} per op,
// handshake hold/turnaround behaviour and reset in the middle of a multiply.
module tb_alu_mc;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inOne;
    logic [31:0] inTwo;
    logic [3:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inOne     (inOne),
        .inTwo     (inTwo),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, measure edges from accept to out_valid, sample, then release.
    task automatic run_vec(input vec_t v, output int lat, output logic [31:0] r,
                           output logic [3:0] f, output logic rel_ok);
        opcode = v.op; inOne = v.a; inTwo = v.b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        f = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rel_ok = (out_valid === 1'b0) && (in_ready === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
        if (result !== 32'h0) begin errors++; $display("FAIL reset result got %h exp 0", result); end
        if (flags !== 4'h0) begin errors++; $display("FAIL reset flags got %b exp 0000", flags); end
        reset = 1'b0;
    endtask

    task automatic test_add_sub();
        vec_t v[5];
        int lat; logic [31:0] r; logic [3:0] f; logic ok;
        v[0] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 0};
        v[1] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 0};
        v[2] = '{4'b1010, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 0};
        v[3] = '{4'b1010, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, 0};
        v[4] = '{4'b1010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 0};
        for (int i = 0; i < 5; i++) begin
            run_vec(v[i], lat, r, f, ok);
            checks += 4;
            if (lat !== v[i].lat) begin errors++; $display("FAIL addsub[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
            if (r !== v[i].r) begin errors++; $display("FAIL addsub[%0d] result got %h exp %h", i, r, v[i].r); end
            if (f !== v[i].f) begin errors++; $display("FAIL addsub[%0d] flags got %b exp %b", i, f, v[i].f); end
            if (ok !== 1'b1) begin errors++; $display("FAIL addsub[%0d] release got %b exp 1", i, ok); end
        end
    endtask

    task automatic test_logic();
        vec_t v[9];
        int lat; logic [31:0] r; logic [3:0] f; logic ok;
        v[0] = '{4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 0};
        v[1] = '{4'b0100, 32'h00F0000F, 32'h0F00F000, 32'h0FF0F00F, 4'b0000, 0};
        v[2] = '{4'b1001, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000, 0};
        v[3] = '{4'b0101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 0};
        v[4] = '{4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 0};
        v[5] = '{4'b1101, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 4'b0000, 0};
        v[6] = '{4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 0};
        v[7] = '{4'b0000, 32'h00000005, 32'h00000003, 32'h00000000, 4'b0100, 0};
        v[8] = '{4'b0001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100, 0};
        for (int i = 0; i < 9; i++) begin
            run_vec(v[i], lat, r, f, ok);
            checks += 3;
            if (lat !== v[i].lat) begin errors++; $display("FAIL logic[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
            if (r !== v[i].r) begin errors++; $display("FAIL logic[%0d] result got %h exp %h", i, r, v[i].r); end
            if (f !== v[i].f) begin errors++; $display("FAIL logic[%0d] flags got %b exp %b", i, f, v[i].f); end
        end
    endtask

    task automatic test_shift();
        vec_t v[6];
        int lat; logic [31:0] r; logic [3:0] f; logic ok;
        v[0] = '{4'b0011, 32'h00000001, 32'd31, 32'h80000000, 4'b1000, 31};
        v[1] = '{4'b1011, 32'h00000003, 32'd1,  32'h00000001, 4'b0010, 1};
        v[2] = '{4'b0011, 32'h80000001, 32'd1,  32'h00000002, 4'b0010, 1};
        v[3] = '{4'b1011, 32'h80000000, 32'd31, 32'h00000001, 4'b0000, 31};
        v[4] = '{4'b0011, 32'h12345678, 32'd32, 32'h12345678, 4'b0000, 0};
        v[5] = '{4'b1011, 32'h0000000F, 32'd4,  32'h00000000, 4'b0110, 4};
        for (int i = 0; i < 6; i++) begin
            run_vec(v[i], lat, r, f, ok);
            checks += 4;
            if (lat !== v[i].lat) begin errors++; $display("FAIL shift[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
            if (r !== v[i].r) begin errors++; $display("FAIL shift[%0d] result got %h exp %h", i, r, v[i].r); end
            if (f !== v[i].f) begin errors++; $display("FAIL shift[%0d] flags got %b exp %b", i, f, v[i].f); end
            if (ok !== 1'b1) begin errors++; $display("FAIL shift[%0d] release got %b exp 1", i, ok); end
        end
    endtask

    task automatic test_mul();
        vec_t v[3];
        int lat; logic [31:0] r; logic [3:0] f; logic ok;
        v[0] = '{4'b1110, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0100, 32};
        v[1] = '{4'b1110, 32'h80000000, 32'h00000003, 32'h80000000, 4'b1000, 32};
        v[2] = '{4'b1110, 32'h00000003, 32'h00000007, 32'h00000015, 4'b0000, 32};
        for (int i = 0; i < 3; i++) begin
            run_vec(v[i], lat, r, f, ok);
            checks += 3;
            if (lat !== v[i].lat) begin errors++; $display("FAIL mul[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
            if (r !== v[i].r) begin errors++; $display("FAIL mul[%0d] result got %h exp %h", i, r, v[i].r); end
            if (f !== v[i].f) begin errors++; $display("FAIL mul[%0d] flags got %b exp %b", i, f, v[i].f); end
        end
        // Full-scale multiply with stray requests while busy; prior result must hold.
        opcode = 4'b1110; inOne = 32'hFFFFFFFF; inTwo = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (lat == 3 || lat == 10) begin
                opcode = 4'b0010; inOne = 32'h1; inTwo = 32'h1; in_valid = 1'b1;
                checks += 3;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy in_ready got %b exp 0", in_ready); end
                if (result !== 32'h15) begin errors++; $display("FAIL mul_busy held result got %h exp 00000015", result); end
                if (flags !== 4'b0000) begin errors++; $display("FAIL mul_busy held flags got %b exp 0000", flags); end
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end
        checks += 3;
        if (lat !== 32) begin errors++; $display("FAIL mul_full latency got %0d exp 32", lat); end
        if (result !== 32'h00000001) begin errors++; $display("FAIL mul_full result got %h exp 00000001", result); end
        if (flags !== 4'b0000) begin errors++; $display("FAIL mul_full flags got %b exp 0000", flags); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        vec_t u;
        int lat; logic [31:0] r; logic [3:0] f; logic ok;
        opcode = 4'b0010; inOne = 32'h1; inTwo = 32'h2; in_valid = 1'b1;
        @(posedge clk); #1;
        opcode = 4'b0111; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL hold[%0d] out_valid got %b exp 1", c, out_valid); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold[%0d] in_ready got %b exp 0", c, in_ready); end
            if (result !== 32'h3) begin errors++; $display("FAIL hold[%0d] result got %h exp 00000003", c, result); end
            if (flags !== 4'b0000) begin errors++; $display("FAIL hold[%0d] flags got %b exp 0000", c, flags); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release out_valid got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release in_ready got %b exp 1", in_ready); end
        u = '{4'b1111, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 4'b0100, 0};
        run_vec(u, lat, r, f, ok);
        checks += 2;
        if (r !== u.r) begin errors++; $display("FAIL undef_op result got %h exp %h", r, u.r); end
        if (f !== u.f) begin errors++; $display("FAIL undef_op flags got %b exp %b", f, u.f); end
    endtask

    task automatic test_back_to_back();
        opcode = 4'b0010; inOne = 32'h1; inTwo = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        // Request held high across the release edge must not be taken on it.
        opcode = 4'b1101; inOne = 32'h55; inTwo = 32'h0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b turnaround out_valid got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b turnaround in_ready got %b exp 1", in_ready); end
        if (result !== 32'h2) begin errors++; $display("FAIL b2b first result got %h exp 00000002", result); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b second out_valid got %b exp 1", out_valid); end
        if (result !== 32'h55) begin errors++; $display("FAIL b2b second result got %h exp 00000055", result); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        vec_t u;
        int lat; logic [31:0] r; logic [3:0] f; logic ok;
        opcode = 4'b1110; inOne = 32'hFFFFFFFF; inTwo = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        opcode = 4'b0010; inOne = 32'h7; inTwo = 32'h7;
        @(posedge clk); #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset in_ready got %b exp 1", in_ready); end
        if (result !== 32'h0) begin errors++; $display("FAIL midreset result got %h exp 0", result); end
        if (flags !== 4'h0) begin errors++; $display("FAIL midreset flags got %b exp 0000", flags); end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        u = '{4'b0010, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 0};
        run_vec(u, lat, r, f, ok);
        checks += 3;
        if (lat !== u.lat) begin errors++; $display("FAIL post_reset_add latency got %0d exp %0d", lat, u.lat); end
        if (r !== u.r) begin errors++; $display("FAIL post_reset_add result got %h exp %h", r, u.r); end
        if (f !== u.f) begin errors++; $display("FAIL post_reset_add flags got %b exp %b", f, u.f); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        inOne = '0; inTwo = '0; opcode = '0;
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_mul();
        test_hold();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks %0d", checks);
        $fatal(1);
    end

endmodule
